// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM encoding, flag logic.
package alu_pkg;

  localparam int MAX_W = 64;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LSR  = 4'b0011;
  localparam logic [3:0] OP_LSL  = 4'b0100;
  localparam logic [3:0] OP_ASR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } flags_t;

  // Flags for a w-bit result; operands arrive zero-extended to MAX_W bits.
  // Bit tests use masks so the width can be a run-time argument.
  function automatic flags_t calcFlags(input logic [MAX_W-1:0] res,
                                       input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input logic [3:0] op,
                                       input int w);
    flags_t f;
    logic [MAX_W:0] sum;
    logic [MAX_W-1:0] msbMask;
    logic [MAX_W:0] carryMask;
    logic aMsb, bMsb, rMsb;
    sum       = {1'b0, a} + {1'b0, b};
    msbMask   = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    carryMask = {{MAX_W{1'b0}}, 1'b1} << w;
    aMsb      = |(a & msbMask);
    bMsb      = |(b & msbMask);
    rMsb      = |(res & msbMask);
    f.zero     = (res == '0);
    f.negative = rMsb;
    f.carry    = 1'b0;
    f.overflow = 1'b0;
    if (op == OP_ADD) begin
      f.carry    = |(sum & carryMask);
      f.overflow = (aMsb == bMsb) && (rMsb != aMsb);
    end else if (op == OP_SUB) begin
      // Carry on subtract is "no borrow"
      f.carry    = (a >= b);
      f.overflow = (aMsb != bMsb) && (rMsb != aMsb);
    end
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier datapath: one partial-product step per enabled cycle.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int n = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         en,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         last,
  output logic [n-1:0] product
);

  localparam int SH = $clog2(n);
  localparam logic [SH-1:0] LAST_CNT = SH'(n - 1);

  logic [n-1:0]  acc;
  logic [n-1:0]  mcand;
  logic [n-1:0]  mplier;
  logic [SH-1:0] cnt;

  // Accumulator value after the current iteration; the top registers it on
  // the final iteration so the result lands on the same edge.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign last    = en && (cnt == LAST_CNT);

  // Load on start, otherwise step once per enabled cycle for all n bits
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
    end else if (en) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SH'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops finish in one cycle, MUL iterates n cycles.
module alu_mc
  import alu_pkg::*;
#(
  parameter int n = 64
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] BusA,
  input  logic [n-1:0] BusB,
  input  logic [3:0]   ALUCtrl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] BusW,
  output logic         Zero,
  output logic         Negative,
  output logic         Carry,
  output logic         Overflow
);

  localparam int SH = $clog2(n);

  state_t              state;
  logic [SH-1:0]       shAmt;
  logic signed [n-1:0] busASigned;
  logic [n-1:0]        aluRes;
  flags_t              aluFlags;
  flags_t              mulFlags;
  logic                mulStart;
  logic                mulEn;
  logic                mulLast;
  logic [n-1:0]        mulProd;

  assign in_ready   = (state == ST_IDLE);
  assign shAmt      = BusB[SH-1:0];
  assign busASigned = BusA;
  assign mulStart   = (state == ST_IDLE) && in_valid && (ALUCtrl == OP_MUL);
  assign mulEn      = (state == ST_MUL);

  alu_mul_seq #(.n(n)) mulSeq (
    .clk     (CLK),
    .rst     (Reset),
    .start   (mulStart),
    .en      (mulEn),
    .a       (BusA),
    .b       (BusB),
    .last    (mulLast),
    .product (mulProd)
  );

  // Single-cycle datapath; unknown opcodes yield zero
  always_comb begin
    aluRes = '0;
    case (ALUCtrl)
      OP_AND:   aluRes = BusA & BusB;
      OP_OR:    aluRes = BusA | BusB;
      OP_ADD:   aluRes = BusA + BusB;
      OP_LSR:   aluRes = BusA >> shAmt;
      OP_LSL:   aluRes = BusA << shAmt;
      OP_ASR:   aluRes = $unsigned(busASigned >>> shAmt);
      OP_SUB:   aluRes = BusA - BusB;
      OP_PASSB: aluRes = BusB;
      OP_XOR:   aluRes = BusA ^ BusB;
      default:  aluRes = '0;
    endcase
    aluFlags = calcFlags(MAX_W'(aluRes), MAX_W'(BusA), MAX_W'(BusB), ALUCtrl, n);
    mulFlags = calcFlags(MAX_W'(mulProd), '0, '0, OP_MUL, n);
  end

  // Control FSM with registered result, flags and out_valid
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      BusW      <= '0;
      {Zero, Negative, Carry, Overflow} <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (ALUCtrl == OP_MUL) begin
              state <= ST_MUL;
            end else begin
              BusW      <= aluRes;
              {Zero, Negative, Carry, Overflow} <= aluFlags;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          if (mulLast) begin
            BusW      <= mulProd;
            {Zero, Negative, Carry, Overflow} <= mulFlags;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Randomized and directed bench for alu_mc at n=64 and n=8 against a behavioural model.
module tb_alu_mc;
  import alu_pkg::*;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  // 64-bit instance
  logic        iv64 = 0, ir64, ov64, or64 = 1;
  logic [63:0] a64 = 0, b64 = 0, w64;
  logic [3:0]  op64 = 0;
  logic        z64, n64, c64, v64;
  // 8-bit instance
  logic        iv8 = 0, ir8, ov8, or8 = 1;
  logic [7:0]  a8 = 0, b8 = 0, w8;
  logic [3:0]  op8 = 0;
  logic        z8, n8, c8, v8;

  alu_mc #(.n(64)) dut64 (
    .CLK(CLK), .Reset(Reset), .in_valid(iv64), .in_ready(ir64),
    .BusA(a64), .BusB(b64), .ALUCtrl(op64), .out_valid(ov64), .out_ready(or64),
    .BusW(w64), .Zero(z64), .Negative(n64), .Carry(c64), .Overflow(v64)
  );

  alu_mc #(.n(8)) dut8 (
    .CLK(CLK), .Reset(Reset), .in_valid(iv8), .in_ready(ir8),
    .BusA(a8), .BusB(b8), .ALUCtrl(op8), .out_valid(ov8), .out_ready(or8),
    .BusW(w8), .Zero(z8), .Negative(n8), .Carry(c8), .Overflow(v8)
  );

  bit          sel8 = 0;
  logic        obsReady, obsValid;
  logic [63:0] obsW;
  logic [3:0]  obsF;
  assign obsReady = sel8 ? ir8 : ir64;
  assign obsValid = sel8 ? ov8 : ov64;
  assign obsW     = sel8 ? {56'd0, w8} : w64;
  assign obsF     = sel8 ? {z8, n8, c8, v8} : {z64, n64, c64, v64};

  int nChk = 0, nErr = 0;
  int acc8 = 0, hs8 = 0, acc64 = 0, hs64 = 0, aborted64 = 0;
  logic [63:0] gotW;
  logic [3:0]  gotF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake bookkeeping
  always @(posedge CLK) begin
    if (!Reset) begin
      if (iv8 && ir8)   acc8++;
      if (ov8 && or8)   hs8++;
      if (iv64 && ir64) acc64++;
      if (ov64 && or64) hs64++;
    end
  end

  // Behavioural model on w-bit values using wide signed/unsigned arithmetic
  task automatic refModel(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                          input int w, output logic [63:0] r, output logic [3:0] f);
    logic [63:0] mask, sign;
    logic signed [127:0] sa, sb, s, lim;
    int sh;
    logic c, v;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    sign = 64'd1 << (w - 1);
    a &= mask;
    b &= mask;
    sa  = $signed({64'd0, a}) - (((a & sign) != 0) ? (128'sd1 <<< w) : 128'sd0);
    sb  = $signed({64'd0, b}) - (((b & sign) != 0) ? (128'sd1 <<< w) : 128'sd0);
    lim = 128'sd1 <<< (w - 1);
    sh  = int'(b % 64'(w));
    c = 0; v = 0; r = 0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin
        r = (a + b) & mask;
        c = ({64'd0, a} + {64'd0, b}) > {64'd0, mask};
        s = sa + sb;
        v = (s >= lim) || (s < -lim);
      end
      4'd3: r = a >> sh;
      4'd4: r = (a << sh) & mask;
      4'd5: begin s = sa >>> sh; r = s[63:0] & mask; end
      4'd6: begin
        r = (a - b) & mask;
        c = (a >= b);
        s = sa - sb;
        v = (s >= lim) || (s < -lim);
      end
      4'd7: r = b;
      4'd8: r = a ^ b;
      4'd9: r = (a * b) & mask;
      default: r = 0;
    endcase
    f = {r == 0, (r & sign) != 0, c, v};
  endtask

  // One transaction: accept, latency, result, optional back-pressure, handshake
  task automatic runOp(input bit s8, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] op, input int hold, input string tag);
    logic [63:0] expW;
    logic [3:0]  expF;
    int w, lat, expLat;
    bit readyWhileBusy;
    sel8 = s8;
    w = s8 ? 8 : 64;
    refModel(a, b, op, w, expW, expF);
    expLat = (op == OP_MUL) ? w + 1 : 1;
    lat = 0;
    while (!obsReady && lat < 200) begin @(posedge CLK); #1; lat++; end
    chk({tag, "/in_ready"}, 64'(obsReady), 64'd1);
    if (s8) begin a8 = a[7:0]; b8 = b[7:0]; op8 = op; iv8 = 1; or8 = (hold == 0); end
    else    begin a64 = a; b64 = b; op64 = op; iv64 = 1; or64 = (hold == 0); end
    @(posedge CLK); #1;
    iv8 = 0; iv64 = 0;
    lat = 1;
    readyWhileBusy = 0;
    while (!obsValid && lat < 200) begin
      if (obsReady) readyWhileBusy = 1;
      @(posedge CLK); #1; lat++;
    end
    chk({tag, "/latency"}, 64'(lat), 64'(expLat));
    chk({tag, "/ready_busy"}, 64'(readyWhileBusy || obsReady), 64'd0);
    gotW = obsW;
    gotF = obsF;
    chk({tag, "/BusW"}, obsW, expW);
    chk({tag, "/ZNCV"}, 64'(obsF), 64'(expF));
    for (int k = 0; k < hold; k++) begin
      @(posedge CLK); #1;
      chk({tag, "/hold_valid"}, 64'(obsValid), 64'd1);
      chk({tag, "/hold_BusW"}, obsW, expW);
    end
    if (s8) or8 = 1; else or64 = 1;
    @(posedge CLK); #1;
    chk({tag, "/ready_after"}, 64'(obsReady), 64'd1);
    chk({tag, "/valid_after"}, 64'(obsValid), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] ra, rb, expW;
    logic [3:0]  rop, expF;
    int lat;
    bit stray;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst/ready64", 64'(ir64), 64'd1);
    chk("rst/valid64", 64'(ov64), 64'd0);
    chk("rst/BusW64", w64, 64'd0);
    chk("rst/flags64", 64'({z64, n64, c64, v64}), 64'd0);
    chk("rst/ready8", 64'(ir8), 64'd1);
    chk("rst/valid8", 64'(ov8), 64'd0);
    chk("rst/BusW8", 64'(w8), 64'd0);
    Reset = 0;

    // Directed cases
    runOp(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 0, "add_ovf");
    chk("add_ovf/W", gotW, 64'h8000_0000_0000_0000);
    chk("add_ovf/ZNCV", 64'(gotF), 64'b0101);
    runOp(0, 64'd5, 64'd5, OP_SUB, 0, "sub_eq");
    chk("sub_eq/ZNCV", 64'(gotF), 64'b1010);
    runOp(0, 64'd3, 64'd5, OP_SUB, 0, "sub_neg");
    chk("sub_neg/W", gotW, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_neg/ZNCV", 64'(gotF), 64'b0100);
    runOp(1, 64'h90, 64'h0B, OP_ASR, 0, "asr8");
    chk("asr8/W", gotW, 64'hF2);
    runOp(1, 64'h90, 64'h0B, OP_LSR, 0, "lsr8");
    chk("lsr8/W", gotW, 64'h12);
    runOp(1, 64'h81, 64'h01, OP_LSL, 0, "lsl8");
    chk("lsl8/W", gotW, 64'h02);
    runOp(1, 64'hFF, 64'h03, OP_MUL, 5, "mul8");
    chk("mul8/W", gotW, 64'hFD);
    chk("mul8/ZNCV", 64'(gotF), 64'b0100);
    runOp(1, 64'h5A, 64'h33, 4'hF, 0, "op15");
    chk("op15/ZNCV", 64'(gotF), 64'b1000);
    runOp(0, 64'h1234_5678_9ABC_DEF1, 64'hFEDC_BA98_7654_3211, OP_MUL, 1, "mul64");

    // Reset during the 10th MUL iteration aborts the operation
    sel8 = 0;
    a64 = 64'd7; b64 = 64'd9; op64 = OP_MUL; or64 = 1; iv64 = 1;
    @(posedge CLK); #1;
    iv64 = 0;
    aborted64++;
    repeat (9) @(posedge CLK);
    #1;
    Reset = 1;
    @(posedge CLK); #1;
    Reset = 0;
    chk("abort/ready", 64'(ir64), 64'd1);
    chk("abort/valid", 64'(ov64), 64'd0);
    chk("abort/BusW", w64, 64'd0);
    stray = 0;
    repeat (80) begin @(posedge CLK); #1; if (ov64) stray = 1; end
    chk("abort/stray", 64'(stray), 64'd0);
    runOp(0, 64'd2, 64'd3, OP_ADD, 0, "post_abort");
    chk("post_abort/W", gotW, 64'd5);

    // Inputs presented while busy must be ignored
    sel8 = 1;
    a8 = 8'h0F; b8 = 8'h11; op8 = OP_MUL; or8 = 0; iv8 = 1;
    @(posedge CLK); #1;
    a8 = 8'hAA; op8 = OP_ADD;
    repeat (3) @(posedge CLK);
    #1;
    chk("busy/ready", 64'(ir8), 64'd0);
    iv8 = 0;
    lat = 4;
    while (!ov8 && lat < 200) begin @(posedge CLK); #1; lat++; end
    chk("busy/latency", 64'(lat), 64'd9);
    refModel(64'h0F, 64'h11, OP_MUL, 8, expW, expF);
    chk("busy/W", 64'(w8), expW);
    iv8 = 1;
    repeat (2) @(posedge CLK);
    #1;
    chk("done/ready", 64'(ir8), 64'd0);
    chk("done/valid", 64'(ov8), 64'd1);
    iv8 = 0;
    or8 = 1;
    @(posedge CLK); #1;
    chk("done/ready_after", 64'(ir8), 64'd1);

    // Randomized traffic on both widths
    for (int i = 0; i < 60; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rop = 4'($urandom_range(0, 15));
      if (i % 5 == 0) rb = rb & 64'h3F;
      runOp(i[0], ra, rb, rop, $urandom_range(0, 2), "rnd");
    end

    repeat (2) @(posedge CLK);
    #1;
    chk("count8", 64'(hs8), 64'(acc8));
    chk("count64", 64'(hs64), 64'(acc64 - aborted64));

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised-width ALU for the ARMv8 datapath: the next-generation execute unit replacing the single-cycle combinational ALU. It keeps the existing 4-bit ALUCtrl encodings and adds ASR, XOR and a sequential shift-add MUL. All four NZCV flags are produced. A valid/ready handshake on both sides lets the pipeline control stall on multi-cycle ops. Results and flags are registered.

## Interface
- n, 64: operand/result width; legal values are powers of two, 8 to 64.
- SH = $clog2(n), derived, not overridable: shift-amount width.

- CLK  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high; clears all state on the CLK edge where it is high.
- in_valid  in  1  operands and opcode presented.
- in_ready  out  1  unit can accept; high only in IDLE.
- BusA  in  n  operand A.
- BusB  in  n  operand B; shift ops use only BusB[SH-1:0].
- ALUCtrl  in  4  opcode.
- out_valid  out  1  BusW and flags valid; held until out_ready.
- out_ready  in  1  consumer accepts the result.
- BusW  out  n  registered result.
- Zero, Negative, Carry, Overflow  out  1 each  registered flags.

## Operation
- Opcodes (pre-existing codes unchanged):
  - AND 0000: BusA & BusB.
  - OR 0001: BusA | BusB.
  - ADD 0010: BusA + BusB.
  - LSR 0011: BusA >> sh, where sh = BusB[SH-1:0].
  - LSL 0100: BusA << sh.
  - ASR 0101: BusA >>> sh.
  - SUB 0110: BusA - BusB.
  - PassB 0111: BusB.
  - XOR 1000: BusA ^ BusB.
  - MUL 1001: low n bits of BusA*BusB, unsigned/signed identical.
  - All other codes: BusW = 0; flags computed from that result.
- Flag rules, applied to the final result:
  - Zero = (BusW == 0).
  - Negative = BusW[n-1].
  - ADD: Carry = carry out of bit n-1; Overflow = (A[n-1]==B[n-1]) && (W[n-1]!=A[n-1]).
  - SUB: Carry = no-borrow, i.e. A >= B unsigned; Overflow = (A[n-1]!=B[n-1]) && (W[n-1]!=A[n-1]).
  - All other ops: Carry = 0, Overflow = 0.
- FSM states: IDLE, MUL, DONE.
  - IDLE & in_valid: capture operands. Non-MUL ops compute and register the result/flags, then go to DONE. MUL loads the multiplier and goes to MUL with iteration counter = 0.
  - MUL: each cycle, if mplier[0] then acc += mcand; mcand <<= 1; mplier >>= 1; counter++. When the counter reaches n-1 and that iteration completes, register the result/flags and go to DONE. No early termination.
  - DONE: out_valid = 1. If out_ready, go to IDLE.
- Inputs are ignored outside IDLE. BusW and flags hold their value until the next result is registered.

## Timing
- Reset values: in_ready = 1 (in IDLE); out_valid = 0; BusW = 0; all flags = 0; FSM = IDLE; counter = 0.
- Reset mid-MUL or in DONE aborts: the next cycle is IDLE with all outputs at reset values, and no result is emitted.
- Latency from the accept edge (in_valid && in_ready) to out_valid high:
  - Non-MUL ops: 1 cycle.
  - MUL: n+1 cycles (n iterations plus DONE entry).
- out_valid && out_ready in cycle k: in_ready = 1 in cycle k+1. The next accept is no earlier than k+1, so there is no same-cycle turnaround.
- Maximum throughput: one non-MUL op per 2 cycles when out_ready is tied high.
- in_ready is a pure function of state, with no combinational path from in_valid or out_ready.
- Reset has priority over every other event on the same edge.

## Structure
- alu_pkg holds:
  - the opcode localparams, using the existing 4-bit values plus ASR, XOR and MUL;
  - the FSM state encoding for IDLE/MUL/DONE;
  - a flag-calculation function taking result, A, B and op.
- One sub-module, alu_mul_seq: the shift-add multiplier datapath (acc, mcand, mplier, counter) with start/done signals. The top level holds the FSM, the single-cycle datapath and the output registers.

## Test plan
- n=64, ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1, out_ready=1 -> 1 cycle later: BusW=0x8000_0000_0000_0000, N=1, V=1, C=0, Z=0; in_ready high the cycle after.
- n=64, SUB A=5, B=5 -> BusW=0, Z=1, C=1, V=0. SUB A=3, B=5 -> BusW=0xFFFF_FFFF_FFFF_FFFE, N=1, C=0.
- n=8, ASR A=0x90, B=0x0B (sh = 3) -> BusW=0xF2, N=1. LSR with the same inputs -> 0x12. LSL A=0x81, B=1 -> 0x02, C=0.
- n=8, MUL A=0xFF, B=0x03 -> out_valid exactly 9 cycles after accept, BusW=0xFD, N=1; in_ready low throughout. With out_ready=0 for 5 cycles, BusW and out_valid are held stable.
- n=64, MUL started, then Reset asserted on the 10th iteration cycle -> next cycle: IDLE, out_valid=0, BusW=0, no stray out_valid afterwards. A new ADD 2+3 then yields 5 with 1-cycle latency.
- Opcode 1111 and in_valid pulsed while busy -> result 0 with Z=1; an input presented while busy produces no extra result (count out_valid handshakes equals count of accepts).
